hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Consumes the ID/EX register's rs1/rs2/rd/control outputs, plus EX/MEM and MEM/WB destination info, and the IF/ID source registers.
- Drives forwarding selects for the EX-stage ALU operands, plus stall/flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Tracks data-memory wait cycles with a timeout, and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 64, consecutive mem_busy_i cycles before the timeout error is raised (range 1..255).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- rs1_id_i  in  5  rs1 of the instruction in ID (from IF/ID).
- rs2_id_i  in  5  rs2 of the instruction in ID.
- rs1_ex_i  in  5  rs1 of the instruction in EX (ID/EX rs1_o).
- rs2_ex_i  in  5  rs2 of the instruction in EX (ID/EX rs2_o).
- rd_ex_i  in  5  rd in EX (ID/EX rd_o).
- RegWrite_ex_i  in  1  EX instruction writes a register.
- WriteSrc_ex_i  in  2  EX write-back source; 2'b01 means load result.
- rd_mem_i  in  5  rd in MEM stage.
- RegWrite_mem_i  in  1  MEM instruction writes a register.
- rd_wb_i  in  5  rd in WB stage.
- RegWrite_wb_i  in  1  WB instruction writes a register.
- PCsrc_ex_i  in  1  taken branch/jump/ret resolved in EX.
- mem_busy_i  in  1  data memory not ready this cycle.
- fwdA_o  out  2  ALU operand A select: 00 ID/EX value, 10 MEM result, 01 WB result.
- fwdB_o  out  2  ALU operand B select, same encoding as fwdA_o.
- stall_pc_o  out  1  hold PC.
- stall_ifid_o  out  1  hold IF/ID.
- stall_idex_o  out  1  hold ID/EX.
- stall_exmem_o  out  1  hold EX/MEM.
- flush_ifid_o  out  1  zero IF/ID next edge.
- flush_idex_o  out  1  zero ID/EX control next edge (bubble).
- mem_timeout_o  out  1  sticky error flag.
- stall_cnt_o  out  CNT_W  cycles with stall_pc_o high.
- flush_cnt_o  out  CNT_W  cycles with flush_idex_o high.

Behaviour:
- Reset (synchronous, rst_i high at posedge):
  - state=RUN, wait counter=0.
  - mem_timeout_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - While rst_i is high, all stall/flush outputs=0 and fwdA_o/fwdB_o=00.
  - Reset mid-wait or mid-stall aborts immediately; there is no pending state.
- Forwarding (combinational, same cycle):
  - A selects 10 if RegWrite_mem_i && rd_mem_i!=0 && rd_mem_i==rs1_ex_i.
  - Otherwise A selects 01 if RegWrite_wb_i && rd_wb_i!=0 && rd_wb_i==rs1_ex_i.
  - Otherwise A selects 00.
  - B is the same using rs2_ex_i.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use condition (LU):
  - LU = RegWrite_ex_i && WriteSrc_ex_i==01 && rd_ex_i!=0 && (rd_ex_i==rs1_id_i || rd_ex_i==rs2_id_i).
- FSM states:
  - RUN.
  - MEM_WAIT.
  - ERR.
- Control outputs are combinational from state and inputs (Mealy), evaluated with this priority:
  1. mem_busy_i=1 (RUN or MEM_WAIT): freeze. stall_pc/ifid/idex/exmem=1, no flushes. LU and PCsrc are ignored this cycle; they re-evaluate once the freeze ends, since the frozen stages hold their values.
  2. PCsrc_ex_i=1: flush_ifid_o=1 and flush_idex_o=1, no stalls. The branch overrides LU because the ID instruction is on the wrong path.
  3. LU: stall_pc_o=1, stall_ifid_o=1, flush_idex_o=1. Exactly one bubble results, because the load advances to MEM next cycle.
  4. Otherwise all stall/flush outputs are 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_busy_i=1, with wait counter=1.
  - In MEM_WAIT with mem_busy_i=1: counter increments.
  - In MEM_WAIT, when the counter reaches MEM_TIMEOUT with mem_busy_i still 1: go to ERR and set mem_timeout_o=1.
  - In MEM_WAIT with mem_busy_i=0: go to RUN, counter=0. Priorities 2–4 apply in that same cycle.
  - ERR: all four stall outputs held at 1 regardless of inputs, no flushes. Only rst_i exits ERR.
- Counters:
  - Each counter increments by 1 on every posedge where its qualifying output is high.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - ERR cycles count as stall cycles.

Test Plan:
- Forwarding:
  - MEM rd=5 RegWrite=1, WB rd=5 RegWrite=1, rs1_ex=5, rs2_ex=6 -> fwdA_o=10, fwdB_o=00.
  - Same setup with rd_mem=0 -> fwdA_o=01.
  - rd_wb=0 also -> fwdA_o=00.
- Load-use: lw x7 in EX (WriteSrc=01, RegWrite=1, rd=7), rs2_id=7 -> one cycle of stall_pc=1, stall_ifid=1, flush_idex=1. Next cycle all 0. stall_cnt_o=1, flush_cnt_o=1.
- Branch plus LU in the same cycle: PCsrc_ex=1 with LU true -> flush_ifid=1, flush_idex=1, stall_pc=0.
- Memory wait:
  - mem_busy_i high 3 cycles -> all four stalls high for exactly 3 cycles, state returns to RUN, mem_timeout_o=0.
  - Pending PCsrc flushes on the first non-busy cycle.
- Timeout with MEM_TIMEOUT=4: mem_busy_i held high -> mem_timeout_o=1 after the 4th busy cycle. Stalls stay 1 after mem_busy_i drops. rst_i pulse clears state, outputs and counters to 0.
- Saturation with CNT_W=3: 10 consecutive LU cycles -> stall_cnt_o stops at 7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V core: EX operand forwarding, load-use
// and branch stall/flush control, data-memory wait tracking and perf counters.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_id_i,
    input  logic [4:0]       rs2_id_i,
    input  logic [4:0]       rs1_ex_i,
    input  logic [4:0]       rs2_ex_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             RegWrite_ex_i,
    input  logic [1:0]       WriteSrc_ex_i,
    input  logic [4:0]       rd_mem_i,
    input  logic             RegWrite_mem_i,
    input  logic [4:0]       rd_wb_i,
    input  logic             RegWrite_wb_i,
    input  logic             PCsrc_ex_i,
    input  logic             mem_busy_i,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic             stall_pc_o,
    output logic             stall_ifid_o,
    output logic             stall_idex_o,
    output logic             stall_exmem_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [8:0] TIMEOUT_V = 9'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [8:0] wait_cnt_inc;
    logic       load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    // MEM result has priority over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_mem, input logic we_mem,
                                           input logic [4:0] rd_wb,  input logic we_wb);
        if (we_mem && rd_mem != 5'd0 && rd_mem == rs) return 2'b10;
        if (we_wb  && rd_wb  != 5'd0 && rd_wb  == rs) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwdA_o = 2'b00;
        fwdB_o = 2'b00;
        if (!rst_i) begin
            fwdA_o = fwd_sel(rs1_ex_i, rd_mem_i, RegWrite_mem_i, rd_wb_i, RegWrite_wb_i);
            fwdB_o = fwd_sel(rs2_ex_i, rd_mem_i, RegWrite_mem_i, rd_wb_i, RegWrite_wb_i);
        end
    end

    assign load_use = RegWrite_ex_i && (WriteSrc_ex_i == 2'b01) && (rd_ex_i != 5'd0) &&
                      ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));

    assign wait_cnt_inc = {1'b0, wait_cnt_q} + 9'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The wait counter holds the number of consecutive busy cycles seen so far.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy_i) begin
                    wait_cnt_d = 8'd1;
                    state_d    = (TIMEOUT_V <= 9'd1) ? ERR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    wait_cnt_d = wait_cnt_inc[7:0];
                    if (wait_cnt_inc >= TIMEOUT_V) state_d = ERR;
                end else begin
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_pc_o    = 1'b0;
        stall_ifid_o  = 1'b0;
        stall_idex_o  = 1'b0;
        stall_exmem_o = 1'b0;
        flush_ifid_o  = 1'b0;
        flush_idex_o  = 1'b0;
        if (!rst_i) begin
            if (state_q == ERR || mem_busy_i) begin
                stall_pc_o    = 1'b1;
                stall_ifid_o  = 1'b1;
                stall_idex_o  = 1'b1;
                stall_exmem_o = 1'b1;
            end else if (PCsrc_ex_i) begin
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
            end else if (load_use) begin
                stall_pc_o   = 1'b1;
                stall_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            if (state_d == ERR) mem_timeout_o <= 1'b1;
            if (stall_pc_o)     stall_cnt_o   <= sat_inc(stall_cnt_o);
            if (flush_idex_o)   flush_cnt_o   <= sat_inc(flush_cnt_o);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan cases plus random traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int CNT_W  = 3;
    localparam int TO     = 4;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic       rw_ex, rw_mem, rw_wb, pcsrc, busy;
        logic [1:0] ws_ex;
    } stim_t;

    typedef struct {
        logic [1:0]       fa, fb;
        logic [5:0]       ctl;
        logic             to;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i = 1'b1;
    logic [4:0]       rs1_id_i = '0, rs2_id_i = '0, rs1_ex_i = '0, rs2_ex_i = '0;
    logic [4:0]       rd_ex_i = '0, rd_mem_i = '0, rd_wb_i = '0;
    logic             RegWrite_ex_i = 0, RegWrite_mem_i = 0, RegWrite_wb_i = 0;
    logic [1:0]       WriteSrc_ex_i = '0;
    logic             PCsrc_ex_i = 0, mem_busy_i = 0;
    logic [1:0]       fwdA_o, fwdB_o;
    logic             stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o;
    logic             flush_ifid_o, flush_idex_o, mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i), .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i),
        .rd_ex_i(rd_ex_i), .RegWrite_ex_i(RegWrite_ex_i), .WriteSrc_ex_i(WriteSrc_ex_i),
        .rd_mem_i(rd_mem_i), .RegWrite_mem_i(RegWrite_mem_i),
        .rd_wb_i(rd_wb_i), .RegWrite_wb_i(RegWrite_wb_i),
        .PCsrc_ex_i(PCsrc_ex_i), .mem_busy_i(mem_busy_i),
        .fwdA_o(fwdA_o), .fwdB_o(fwdB_o),
        .stall_pc_o(stall_pc_o), .stall_ifid_o(stall_ifid_o),
        .stall_idex_o(stall_idex_o), .stall_exmem_o(stall_exmem_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: consecutive busy cycles, error latch, counters as plain ints.
    int m_busy_run = 0;
    bit m_err = 0, m_to = 0;
    int m_sc = 0, m_fc = 0;

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (s.rw_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b10;
        if (s.rw_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   lu, spc, fidex;
        @(posedge clk);
        #1;
        rst_i = s.rst; rs1_id_i = s.rs1_id; rs2_id_i = s.rs2_id;
        rs1_ex_i = s.rs1_ex; rs2_ex_i = s.rs2_ex; rd_ex_i = s.rd_ex;
        RegWrite_ex_i = s.rw_ex; WriteSrc_ex_i = s.ws_ex;
        rd_mem_i = s.rd_mem; RegWrite_mem_i = s.rw_mem;
        rd_wb_i = s.rd_wb; RegWrite_wb_i = s.rw_wb;
        PCsrc_ex_i = s.pcsrc; mem_busy_i = s.busy;

        lu = s.rw_ex && s.ws_ex == 2'b01 && s.rd_ex != 0 &&
             (s.rd_ex == s.rs1_id || s.rd_ex == s.rs2_id);
        e.fa  = s.rst ? 2'b00 : ref_fwd(s, s.rs1_ex);
        e.fb  = s.rst ? 2'b00 : ref_fwd(s, s.rs2_ex);
        if (s.rst)                   e.ctl = 6'b000000;
        else if (m_err || s.busy)    e.ctl = 6'b111100;
        else if (s.pcsrc)            e.ctl = 6'b000011;
        else if (lu)                 e.ctl = 6'b110001;
        else                         e.ctl = 6'b000000;
        e.to = m_to;
        e.sc = m_sc[CNT_W-1:0];
        e.fc = m_fc[CNT_W-1:0];
        sb.push_back(e);

        spc   = e.ctl[5];
        fidex = e.ctl[0];
        if (s.rst) begin
            m_busy_run = 0; m_err = 0; m_to = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (!m_err) begin
                if (s.busy) begin
                    m_busy_run++;
                    if (m_busy_run >= TO) begin m_err = 1; m_to = 1; end
                end else m_busy_run = 0;
            end
            if (spc)   m_sc = (m_sc < CNTMAX) ? m_sc + 1 : CNTMAX;
            if (fidex) m_fc = (m_fc < CNTMAX) ? m_fc + 1 : CNTMAX;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 0, rs1_id: 1, rs2_id: 2, rs1_ex: 3, rs2_ex: 4, rd_ex: 8,
              rd_mem: 9, rd_wb: 10, rw_ex: 0, rw_mem: 0, rw_wb: 0,
              pcsrc: 0, busy: 0, ws_ex: 2'b00};
        return s;
    endfunction

    // Monitor: every cycle the DUT presents a full output set; compare against queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if ({fwdA_o, fwdB_o} !== {e.fa, e.fb}) begin
                    n_fail++;
                    $display("FAIL fwd @%0t: got A=%b B=%b expected A=%b B=%b",
                             $time, fwdA_o, fwdB_o, e.fa, e.fb);
                end
                n_tests++;
                if ({stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o,
                     flush_ifid_o, flush_idex_o} !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl @%0t: got %b expected %b", $time,
                             {stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o,
                              flush_ifid_o, flush_idex_o}, e.ctl);
                end
                n_tests++;
                if ({mem_timeout_o, stall_cnt_o, flush_cnt_o} !== {e.to, e.sc, e.fc}) begin
                    n_fail++;
                    $display("FAIL cnt @%0t: got to=%b sc=%0d fc=%0d expected to=%b sc=%0d fc=%0d",
                             $time, mem_timeout_o, stall_cnt_o, flush_cnt_o, e.to, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        repeat (2) @(posedge clk);

        // Reset with hazardous inputs: outputs must be quiet.
        s = idle(); s.rst = 1; s.busy = 1; s.pcsrc = 1;
        s.rw_mem = 1; s.rd_mem = 3; step(s);

        // Forwarding priority and x0 suppression.
        s = idle(); s.rw_mem = 1; s.rd_mem = 5; s.rw_wb = 1; s.rd_wb = 5;
        s.rs1_ex = 5; s.rs2_ex = 6; step(s);
        s.rd_mem = 0; step(s);
        s.rd_wb = 0; step(s);

        // Single load-use bubble.
        s = idle(); s.rw_ex = 1; s.ws_ex = 2'b01; s.rd_ex = 7; s.rs2_id = 7; step(s);
        step(idle()); step(idle());

        // Branch wins over load-use.
        s = idle(); s.rw_ex = 1; s.ws_ex = 2'b01; s.rd_ex = 7; s.rs1_id = 7; s.pcsrc = 1;
        step(s); step(idle());

        // Three busy cycles, then a pending branch flushes on release.
        s = idle(); s.busy = 1; s.pcsrc = 1;
        repeat (3) step(s);
        s.busy = 0; step(s); step(idle());

        // Timeout: busy for five cycles, stuck in error, reset recovers.
        s = idle(); s.busy = 1;
        repeat (5) step(s);
        repeat (3) step(idle());
        s = idle(); s.rst = 1; step(s);
        repeat (2) step(idle());

        // Counter saturation with ten back-to-back load-use cycles.
        s = idle(); s.rw_ex = 1; s.ws_ex = 2'b01; s.rd_ex = 7; s.rs2_id = 7;
        repeat (10) step(s);
        repeat (2) step(idle());

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            s.rst    = ($urandom_range(0, 59) == 0);
            s.rs1_id = 5'($urandom_range(0, 3)); s.rs2_id = 5'($urandom_range(0, 3));
            s.rs1_ex = 5'($urandom_range(0, 3)); s.rs2_ex = 5'($urandom_range(0, 3));
            s.rd_ex  = 5'($urandom_range(0, 3)); s.rd_mem = 5'($urandom_range(0, 3));
            s.rd_wb  = 5'($urandom_range(0, 3));
            s.rw_ex  = 1'($urandom_range(0, 1)); s.rw_mem = 1'($urandom_range(0, 1));
            s.rw_wb  = 1'($urandom_range(0, 1)); s.ws_ex  = 2'($urandom_range(0, 3));
            s.pcsrc  = ($urandom_range(0, 4) == 0);
            s.busy   = ($urandom_range(0, 5) == 0);
            step(s);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
